// File: rtl/uart_trx_param.sv
// Single-clock full-duplex UART with built-in baud divider, 1/2 stop bits and 3-sample RX voting.
// Define UART_LOOPBACK_EN to add the LOOPBACK port (TX stream fed to RX, TX_OUT pin held high).
module uart_trx_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef UART_LOOPBACK_EN
  input  logic                  LOOPBACK,
`endif
  input  logic [DIV_W-1:0]      BAUD_DIV,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [DATA_WIDTH-1:0] TX_P_DATA,
  input  logic                  TX_P_DATA_VALID,
  output logic                  TX_OUT,
  output logic                  busy,
  input  logic                  RX_IN,
  output logic [DATA_WIDTH-1:0] RX_P_DATA,
  output logic                  RX_P_DATA_VALID,
  output logic                  par_error,
  output logic                  stop_error
);

  localparam int unsigned      BIT_W    = $clog2(DATA_WIDTH);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  state_t                r_tx_state, w_tx_state_n, r_rx_state, w_rx_state_n;
  logic [DIV_W-1:0]      r_tx_div_cnt, w_tx_div_cnt_n, r_tx_div, w_tx_div_n;
  logic [PRESC_W-1:0]    r_tx_tick, w_tx_tick_n, r_tx_presc, w_tx_presc_n;
  logic [BIT_W-1:0]      r_tx_bit, w_tx_bit_n;
  logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_n;
  logic                  r_tx_pen, w_tx_pen_n, r_tx_ptyp, w_tx_ptyp_n, r_tx_stop2, w_tx_stop2_n;
  logic                  r_tx_out, w_tx_out_n, r_busy, w_busy_n, r_tx_pin;
  logic                  w_tx_tick, w_tx_bit_done, w_loop, w_rx_src;

  logic                  r_sync1, r_sync2, r_sync_prev;
  logic [DIV_W-1:0]      r_rx_div_cnt, w_rx_div_cnt_n, r_rx_div, w_rx_div_n;
  logic [PRESC_W-1:0]    r_rx_tick, w_rx_tick_n, r_rx_presc, w_rx_presc_n, w_mid;
  logic [BIT_W-1:0]      r_rx_bit, w_rx_bit_n;
  logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_n, r_rx_data, w_rx_data_n;
  logic                  r_rx_pen, w_rx_pen_n, r_rx_ptyp, w_rx_ptyp_n, r_rx_stop2, w_rx_stop2_n;
  logic [1:0]            r_votes, w_votes_n;
  logic                  r_perr, w_perr_n, r_serr, w_serr_n;
  logic                  r_rx_valid, w_rx_valid_n, r_par_err, w_par_err_n, r_stop_err, w_stop_err_n;
  logic                  w_rx_tick, w_rx_bit_done, w_s1, w_s2, w_s3, w_vote, w_stop_err, w_rx_done;
  logic [DIV_W-1:0]      w_div_max;

  assign w_div_max = (BAUD_DIV == '0) ? DIV_W'(1) : BAUD_DIV;

`ifdef UART_LOOPBACK_EN
  logic r_loop;
  // Loopback mode only changes between frames
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_loop <= 1'b0;
    else if (r_tx_state == S_IDLE && r_rx_state == S_IDLE) r_loop <= LOOPBACK;
  end
  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_tx_tick     = (r_tx_div_cnt == r_tx_div - DIV_W'(1));
  assign w_tx_bit_done = w_tx_tick && (r_tx_tick == r_tx_presc - PRESC_W'(1));

  always_comb begin : tx_next
    w_tx_state_n   = r_tx_state;
    w_tx_div_cnt_n = w_tx_tick ? '0 : r_tx_div_cnt + DIV_W'(1);
    w_tx_tick_n    = r_tx_tick;
    if (w_tx_tick) w_tx_tick_n = w_tx_bit_done ? '0 : r_tx_tick + PRESC_W'(1);
    w_tx_bit_n     = r_tx_bit;
    w_tx_data_n    = r_tx_data;
    w_tx_div_n     = r_tx_div;
    w_tx_presc_n   = r_tx_presc;
    w_tx_pen_n     = r_tx_pen;
    w_tx_ptyp_n    = r_tx_ptyp;
    w_tx_stop2_n   = r_tx_stop2;
    w_tx_out_n     = r_tx_out;
    w_busy_n       = r_busy;
    case (r_tx_state)
      S_IDLE: if (TX_P_DATA_VALID) begin
        w_tx_state_n   = S_START;
        w_tx_data_n    = TX_P_DATA;
        w_tx_pen_n     = PAR_EN;
        w_tx_ptyp_n    = PAR_TYP;
        w_tx_stop2_n   = STOP2;
        w_tx_div_n     = w_div_max;
        w_tx_presc_n   = PRESCALE;
        w_tx_div_cnt_n = '0;
        w_tx_tick_n    = '0;
        w_tx_bit_n     = '0;
        w_tx_out_n     = 1'b0;
        w_busy_n       = 1'b1;
      end
      S_START: if (w_tx_bit_done) begin
        w_tx_state_n = S_DATA;
        w_tx_out_n   = r_tx_data[0];
      end
      S_DATA: if (w_tx_bit_done) begin
        if (r_tx_bit == LAST_BIT) begin
          w_tx_state_n = r_tx_pen ? S_PARITY : S_STOP1;
          w_tx_out_n   = r_tx_pen ? ((^r_tx_data) ^ r_tx_ptyp) : 1'b1;
        end else begin
          w_tx_bit_n = r_tx_bit + BIT_W'(1);
          w_tx_out_n = r_tx_data[r_tx_bit + BIT_W'(1)];
        end
      end
      S_PARITY: if (w_tx_bit_done) begin
        w_tx_state_n = S_STOP1;
        w_tx_out_n   = 1'b1;
      end
      S_STOP1: if (w_tx_bit_done) begin
        w_tx_state_n = r_tx_stop2 ? S_STOP2 : S_IDLE;
        w_busy_n     = r_tx_stop2;
      end
      S_STOP2: if (w_tx_bit_done) begin
        w_tx_state_n = S_IDLE;
        w_busy_n     = 1'b0;
      end
      default: w_tx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tx_state <= S_IDLE;   r_tx_div_cnt <= '0;         r_tx_tick <= '0;
      r_tx_div   <= DIV_W'(1); r_tx_presc  <= PRESC_W'(8); r_tx_bit  <= '0;
      r_tx_data  <= '0;       r_tx_pen     <= 1'b0;       r_tx_ptyp <= 1'b0;
      r_tx_stop2 <= 1'b0;     r_tx_out     <= 1'b1;       r_busy    <= 1'b0;
      r_tx_pin   <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n; r_tx_div_cnt <= w_tx_div_cnt_n; r_tx_tick <= w_tx_tick_n;
      r_tx_div   <= w_tx_div_n;   r_tx_presc   <= w_tx_presc_n;   r_tx_bit  <= w_tx_bit_n;
      r_tx_data  <= w_tx_data_n;  r_tx_pen     <= w_tx_pen_n;     r_tx_ptyp <= w_tx_ptyp_n;
      r_tx_stop2 <= w_tx_stop2_n; r_tx_out     <= w_tx_out_n;     r_busy    <= w_busy_n;
      r_tx_pin   <= w_tx_out_n | w_loop;
    end
  end

  assign TX_OUT = r_tx_pin;
  assign busy   = r_busy;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  assign w_rx_src = w_loop ? r_tx_out : RX_IN;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1 <= 1'b1; r_sync2 <= 1'b1; r_sync_prev <= 1'b1;
    end else begin
      r_sync1 <= w_rx_src; r_sync2 <= r_sync1; r_sync_prev <= r_sync2;
    end
  end

  assign w_rx_tick     = (r_rx_div_cnt == r_rx_div - DIV_W'(1));
  assign w_rx_bit_done = w_rx_tick && (r_rx_tick == r_rx_presc - PRESC_W'(1));
  assign w_mid         = r_rx_presc >> 1;
  assign w_s1          = w_rx_tick && (r_rx_tick == w_mid - PRESC_W'(1));
  assign w_s2          = w_rx_tick && (r_rx_tick == w_mid);
  assign w_s3          = w_rx_tick && (r_rx_tick == w_mid + PRESC_W'(1));
  assign w_vote        = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_sync2) | (r_votes[1] & r_sync2);
  assign w_stop_err    = r_serr | ~w_vote;

  always_comb begin : rx_next
    w_rx_state_n   = r_rx_state;
    w_rx_div_cnt_n = w_rx_tick ? '0 : r_rx_div_cnt + DIV_W'(1);
    w_rx_tick_n    = r_rx_tick;
    if (w_rx_tick) w_rx_tick_n = w_rx_bit_done ? '0 : r_rx_tick + PRESC_W'(1);
    w_rx_bit_n     = r_rx_bit;
    w_rx_shift_n   = r_rx_shift;
    w_rx_div_n     = r_rx_div;
    w_rx_presc_n   = r_rx_presc;
    w_rx_pen_n     = r_rx_pen;
    w_rx_ptyp_n    = r_rx_ptyp;
    w_rx_stop2_n   = r_rx_stop2;
    w_votes_n      = r_votes;
    w_perr_n       = r_perr;
    w_serr_n       = r_serr;
    w_rx_data_n    = r_rx_data;
    w_rx_valid_n   = 1'b0;
    w_par_err_n    = 1'b0;
    w_stop_err_n   = 1'b0;
    w_rx_done      = 1'b0;
    if (w_s1) w_votes_n[0] = r_sync2;
    if (w_s2) w_votes_n[1] = r_sync2;
    case (r_rx_state)
      S_IDLE: if (r_sync_prev && !r_sync2) begin
        w_rx_state_n   = S_START;
        w_rx_pen_n     = PAR_EN;
        w_rx_ptyp_n    = PAR_TYP;
        w_rx_stop2_n   = STOP2;
        w_rx_div_n     = w_div_max;
        w_rx_presc_n   = PRESCALE;
        w_rx_div_cnt_n = '0;
        w_rx_tick_n    = '0;
        w_rx_bit_n     = '0;
        w_perr_n       = 1'b0;
        w_serr_n       = 1'b0;
      end
      S_START: begin
        if (w_s3 && w_vote) w_rx_state_n = S_IDLE;
        else if (w_rx_bit_done) w_rx_state_n = S_DATA;
      end
      S_DATA: begin
        if (w_s3) w_rx_shift_n = {w_vote, r_rx_shift[DATA_WIDTH-1:1]};
        if (w_rx_bit_done) begin
          if (r_rx_bit == LAST_BIT) w_rx_state_n = r_rx_pen ? S_PARITY : S_STOP1;
          else w_rx_bit_n = r_rx_bit + BIT_W'(1);
        end
      end
      S_PARITY: begin
        if (w_s3) w_perr_n = w_vote ^ (^r_rx_shift) ^ r_rx_ptyp;
        if (w_rx_bit_done) w_rx_state_n = S_STOP1;
      end
      S_STOP1: begin
        if (w_s3) begin
          w_serr_n  = w_stop_err;
          w_rx_done = !r_rx_stop2;
        end
        if (w_rx_bit_done && r_rx_stop2) w_rx_state_n = S_STOP2;
      end
      S_STOP2: if (w_s3) w_rx_done = 1'b1;
      default: w_rx_state_n = S_IDLE;
    endcase
    // Leave at the last stop sample so half a bit remains to catch the next start edge
    if (w_rx_done) begin
      w_rx_state_n = S_IDLE;
      if (!r_perr && !w_stop_err) begin
        w_rx_data_n  = r_rx_shift;
        w_rx_valid_n = 1'b1;
      end else begin
        w_par_err_n  = r_perr;
        w_stop_err_n = w_stop_err;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rx_state <= S_IDLE;    r_rx_div_cnt <= '0;         r_rx_tick  <= '0;
      r_rx_div   <= DIV_W'(1); r_rx_presc   <= PRESC_W'(8); r_rx_bit   <= '0;
      r_rx_shift <= '0;        r_rx_pen     <= 1'b0;       r_rx_ptyp  <= 1'b0;
      r_rx_stop2 <= 1'b0;      r_votes      <= 2'b11;      r_perr     <= 1'b0;
      r_serr     <= 1'b0;      r_rx_data    <= '0;         r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;      r_stop_err   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_n; r_rx_div_cnt <= w_rx_div_cnt_n; r_rx_tick  <= w_rx_tick_n;
      r_rx_div   <= w_rx_div_n;   r_rx_presc   <= w_rx_presc_n;   r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n; r_rx_pen     <= w_rx_pen_n;     r_rx_ptyp  <= w_rx_ptyp_n;
      r_rx_stop2 <= w_rx_stop2_n; r_votes      <= w_votes_n;      r_perr     <= w_perr_n;
      r_serr     <= w_serr_n;     r_rx_data    <= w_rx_data_n;    r_rx_valid <= w_rx_valid_n;
      r_par_err  <= w_par_err_n;  r_stop_err   <= w_stop_err_n;
    end
  end

  assign RX_P_DATA       = r_rx_data;
  assign RX_P_DATA_VALID = r_rx_valid;
  assign par_error       = r_par_err;
  assign stop_error      = r_stop_err;

endmodule
